des3_out_collector: RTL
=======================

Name: des3_out_collector

Overview:
- Downstream stage of des3_perf.
- Tracks which pipeline slots carry real blocks using a valid delay line matched to the des3_perf latency.
- Captures each valid 64-bit result into a small FIFO and serializes it as four 16-bit words over a valid/ready interface toward the LED/host side.
- des3_perf cannot stall, so this block absorbs bursts and flags any loss.

Parameters:
- LATENCY, 48, cycles from a block entering des3_perf to its result on desOut; must be >= 1.
- DEPTH, 4, FIFO entries of 64 bits; power of two, >= 2.
- CW, 3, width of fifo_count; equals log2(DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  high in the same cycle a real block is presented to des3_perf desIn.
- des_out  in  64  des3_perf desOut.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_valid  out  1  out_data holds a valid word.
- out_data  out  16  current word; MSW (des_out[63:48]) first.
- out_last  out  1  high with the 4th word (bits [15:0]) of a block.
- overflow  out  1  sticky: a valid result was dropped because the FIFO was full.
- fifo_count  out  CW  number of blocks held, including the one being serialized.

Behaviour:
- Reset (rst_n low, asynchronous): clear the valid delay line, FIFO pointers, fifo_count, word index and overflow.
  - out_valid=0, out_last=0, out_data=0, overflow=0, fifo_count=0.
  - FIFO storage RAM need not be cleared.
- Valid delay line: LATENCY-stage shift register fed by in_valid.
  - Its tap cap_en is high in cycle t+LATENCY for in_valid in cycle t.
- Capture: on the clk edge ending a cycle with cap_en=1, des_out is written at the write pointer.
  - Condition: fifo_count<DEPTH, or a pop occurs in the same cycle.
  - Otherwise the result is discarded and overflow is set; it stays set until reset.
- Pop: occurs when out_valid && out_ready && out_last. It advances the read pointer and resets word index to 0.
- Simultaneous push and pop: fifo_count unchanged; a push with the FIFO full plus a pop is accepted.
- Serializer: 2-bit word index w, 0..3, selects head[63-16w -: 16].
  - out_valid = (fifo_count != 0). out_last = out_valid && (w==3).
  - w increments only on out_valid && out_ready; it wraps 3->0 on pop.
  - out_data is registered or driven from the head entry. It must be stable while out_valid && !out_ready.
  - When fifo_count==0, out_data holds its previous value.
- Latency: with the FIFO empty, in_valid at cycle t gives out_valid=1 first in cycle t+LATENCY+1.
  - Back-to-back words at full throughput give 4 cycles per block.
- Throughput mismatch: des3_perf can deliver 1 block/cycle while the output drains 1 block per 4 cycles. Sustained input above 1/4 rate overflows by design; the upstream must rate-limit.
- Backpressure (out_ready low) only stalls the serializer. It never affects the delay line or capture.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are taken from fifo_count.
- fifo_count is registered: +1 on push only, -1 on pop only.

Decomposition:
- Shared package des3_pkg:
  - DES_BLK_W=64, DES_KEY_W=56, OUT_W=16, WORDS_PER_BLK=4.
  - DES3_PERF_LATENCY=48, also used as the LATENCY default by the top level.
- One sub-module: des3_blk_fifo.
  - Synchronous-write, DEPTH x 64 FIFO with count, push/pop, and a head data output.
  - Same clk/rst_n convention.
- Delay line, overflow logic and serializer stay in des3_out_collector.

Test Plan:
- Single block: after reset, in_valid at cycle 0, des_out=64'h0123456789ABCDEF at cycle 48, out_ready=1.
  -> out_valid cycles 49-52 with out_data 0123, 4567, 89AB, CDEF. out_last only in cycle 52. fifo_count returns to 0.
- Backpressure: same block, out_ready held 0 for 10 cycles, then 1.
  -> out_data stays 16'h0123 with out_valid=1 the whole stall. The remaining words follow in order. No overflow.
- Burst overflow: in_valid high 6 consecutive cycles with distinct des_out values, out_ready=0.
  -> fifo_count saturates at 4 and overflow=1. After draining, the first 4 blocks appear in order and blocks 5-6 are absent.
- Full with simultaneous pop: FIFO at 4, cap_en coincides with acceptance of an out_last word.
  -> the new block is stored, fifo_count stays 4, overflow stays 0.
- Mid-operation reset: assert rst_n low while serializing word 2 with 3 blocks queued.
  -> out_valid, out_last, fifo_count and overflow go 0 immediately (asynchronously). Pending delay-line valids are lost. No output after release until a new in_valid+48.
- Rate 1/4: in_valid every 4th cycle for 100 blocks, out_ready=1.
  -> all 100 blocks emitted in order, overflow=0, fifo_count never exceeds 2.

Source files
------------

// File: rtl/des3_pkg.sv
// Shared constants for the des3 datapath and its output collector.
// blk_word picks one 16-bit slice of a block, most significant word first.
package des3_pkg;

    localparam int DES_BLK_W         = 64;
    localparam int DES_KEY_W         = 56;
    localparam int OUT_W             = 16;
    localparam int WORDS_PER_BLK     = 4;
    localparam int DES3_PERF_LATENCY = 48;

    typedef logic [1:0] word_idx_t;

    function automatic logic [OUT_W-1:0] blk_word(input logic [DES_BLK_W-1:0] blk,
                                                  input word_idx_t idx);
        logic [OUT_W-1:0] w;
        case (idx)
            2'd0:    w = blk[63:48];
            2'd1:    w = blk[47:32];
            2'd2:    w = blk[31:16];
            default: w = blk[15:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/des3_blk_fifo.sv
// Small block FIFO with occupancy count and a combinational head output.
// The caller gates push; storage is not reset.
module des3_blk_fifo
    import des3_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DES_BLK_W-1:0] din,
    output logic [DES_BLK_W-1:0] head,
    output logic [CW-1:0]        count
);

    localparam int AW = $clog2(DEPTH);

    logic [DES_BLK_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [CW-1:0]        count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // A full-FIFO push alongside a pop writes the slot being vacated.
    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/des3_out_collector.sv
// Collects des3_perf results by a valid delay line, buffers them and
// serializes each block as four 16-bit words, flagging dropped results.
module des3_out_collector
    import des3_pkg::*;
#(
    parameter int LATENCY = DES3_PERF_LATENCY,
    parameter int DEPTH   = 4,
    parameter int CW      = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DES_BLK_W-1:0] des_out,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_last,
    output logic                 overflow,
    output logic [CW-1:0]        fifo_count
);

    logic [LATENCY-1:0]   dly_reg;
    logic                 cap_en;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 overflow_reg;
    word_idx_t            w_reg;
    logic [OUT_W-1:0]     hold_reg;
    logic [OUT_W-1:0]     head_word;
    logic [DES_BLK_W-1:0] head;

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_dly
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) dly_reg[gi] <= 1'b0;
                    else        dly_reg[gi] <= in_valid;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) dly_reg[gi] <= 1'b0;
                    else        dly_reg[gi] <= dly_reg[gi-1];
                end
            end
        end
    endgenerate

    assign cap_en    = dly_reg[LATENCY-1];
    assign full      = (fifo_count == CW'(DEPTH));
    assign out_valid = (fifo_count != '0);
    assign out_last  = out_valid && (w_reg == 2'd3);
    assign pop       = out_valid && out_ready && out_last;
    assign push      = cap_en && (!full || pop);

    des3_blk_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (des_out),
        .head  (head),
        .count (fifo_count)
    );

    assign head_word = blk_word(head, w_reg);
    // When empty, keep showing the last word handed out rather than stale RAM.
    assign out_data  = out_valid ? head_word : hold_reg;
    assign overflow  = overflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg        <= '0;
            hold_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (out_valid && out_ready) w_reg <= w_reg + 1'b1;
            if (out_valid)              hold_reg <= head_word;
            if (cap_en && full && !pop) overflow_reg <= 1'b1;
        end
    end

endmodule
